shift_reg_universal: RTL



---
 rtl/shift_reg_universal.sv | 125 ++++++++++++
 1 files changed

// File: rtl/shift_reg_universal.sv
// Universal WIDTH-bit shift register: parallel load, shift, rotate and arithmetic shift,
// stepping one bit per clock for a latched amount and pulsing done on completion.
module shift_reg_universal #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      AMT_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    ModeHold = 3'b000,
    ModeLoad = 3'b001,
    ModeShl  = 3'b010,
    ModeShr  = 3'b011,
    ModeRol  = 3'b100,
    ModeRor  = 3'b101,
    ModeAsr  = 3'b110,
    ModeRsvd = 3'b111
  } mode_e;

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] q_d;
  logic             busy_d, done_d;
  mode_e            start_mode;
  logic             start_shifts;

  // One single-bit step of a shift/rotate; non-shift modes leave the value untouched.
  function automatic logic [WIDTH-1:0] shift_step(input mode_e op, input logic [WIDTH-1:0] val,
                                                  input logic s);
    logic [WIDTH-1:0] res;
    res = val;
    case (op)
      ModeShl: res = {val[WIDTH-2:0], s};
      ModeShr: res = {s, val[WIDTH-1:1]};
      ModeRol: res = {val[WIDTH-2:0], val[WIDTH-1]};
      ModeRor: res = {val[0], val[WIDTH-1:1]};
      ModeAsr: res = {val[WIDTH-1], val[WIDTH-1:1]};
      default: res = val;
    endcase
    return res;
  endfunction

  assign start_mode   = mode_e'(mode);
  assign start_shifts = start_mode inside {ModeShl, ModeShr, ModeRol, ModeRor, ModeAsr};

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    remaining_d = remaining_q;
    q_d         = q;
    busy_d      = busy;
    done_d      = 1'b0;

    if (clear) begin
      state_d     = StIdle;
      remaining_d = '0;
      q_d         = '0;
      busy_d      = 1'b0;
    end else if (state_q == StRun) begin
      q_d = shift_step(mode_q, q, sin);
      if (remaining_q == AMT_W'(1)) begin
        state_d     = StIdle;
        remaining_d = '0;
        busy_d      = 1'b0;
        done_d      = 1'b1;
      end else begin
        remaining_d = remaining_q - AMT_W'(1);
      end
    end else if (start) begin
      mode_d = start_mode;
      done_d = 1'b1;
      if (start_mode == ModeLoad) begin
        q_d = d;
      end else if (start_shifts && amount != '0) begin
        // First step happens on the accepting edge; only multi-step commands enter RUN.
        q_d = shift_step(start_mode, q, sin);
        if (amount != AMT_W'(1)) begin
          state_d     = StRun;
          remaining_d = amount - AMT_W'(1);
          busy_d      = 1'b1;
          done_d      = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      mode_q      <= ModeHold;
      remaining_q <= '0;
      q           <= RESET_VAL;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      remaining_q <= remaining_d;
      q           <= q_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  assign sout_msb = q[WIDTH-1];
  assign sout_lsb = q[0];

endmodule
